bus_xfer_ctrl: RTL and testbench

Sequencer for the shared 16-bit register bus. It accepts register-transfer commands over a valid/ready handshake and drives the per-register control lines (read, load, inc, clear) of up to NREG bus registers. It sits between the instruction decode/control unit and the register file of DR-style registers. A register's bus output updates one clock after its read line rises, so the sequencer always asserts the source's read line one cycle before it asserts the destination's load line.

---
 rtl/bus_ctrl_pkg.sv | 29 ++
 rtl/bus_xfer_ctrl_if.sv | 37 +++
 rtl/bus_xfer_ctrl_sel_decoder.sv | 23 ++
 rtl/bus_xfer_ctrl.sv | 114 +++++++++++
 tb/tb_bus_xfer_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bus_ctrl_pkg
// Shared types for the register-bus transfer sequencer: the sequencer state
// encoding, the command opcodes and a small opcode classification helper.
// No ports (package).
// -----------------------------------------------------------------------------
package bus_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        LATCH,
        EXEC,
        INCR
    } state_e;

    typedef enum logic [1:0] {
        OP_MOVE    = 2'b00,
        OP_CLR     = 2'b01,
        OP_INC     = 2'b10,
        OP_MOVEINC = 2'b11
    } op_e;

    // Transfer ops move data across the bus and need distinct src/dst.
    function automatic logic is_transfer(op_e op);
        return (op == OP_MOVE) || (op == OP_MOVEINC);
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl_if
// Command handshake plus per-register control lines of the register-bus
// sequencer.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/src/dst      : command fields (stable while cmd_valid is held)
//   reg_read/load/inc/clear : one-hot control lines, one bit per register
//   busy/done/err       : sequencer status
// Modports: master = command source / status sink, slave = sequencer.
// -----------------------------------------------------------------------------
interface bus_xfer_ctrl_if #(
    parameter int NREG = 8,
    parameter int SELW = 3
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [SELW-1:0] cmd_src;
    logic [SELW-1:0] cmd_dst;
    logic [NREG-1:0] reg_read;
    logic [NREG-1:0] reg_load;
    logic [NREG-1:0] reg_inc;
    logic [NREG-1:0] reg_clear;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst,
        input  cmd_ready, reg_read, reg_load, reg_inc, reg_clear, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst,
        output cmd_ready, reg_read, reg_load, reg_inc, reg_clear, busy, done, err
    );
endinterface

// File: rtl/bus_xfer_ctrl_sel_decoder.sv
// -----------------------------------------------------------------------------
// sel_decoder
// Register index to one-hot select. An index outside 0..NREG-1 or a low
// enable yields all zeros.
//   sel    : SELW-bit register index
//   en     : decode enable
//   onehot : NREG-bit one-hot select
// -----------------------------------------------------------------------------
module sel_decoder #(
    parameter int NREG = 8,
    parameter int SELW = 3
) (
    input  logic [SELW-1:0] sel,
    input  logic            en,
    output logic [NREG-1:0] onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            if (en && (sel == SELW'(i))) onehot[i] = 1'b1;
        end
    end
endmodule

// File: rtl/bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl
// Sequencer for the shared 16-bit register bus. Accepts MOVE / CLR / INC /
// MOVEINC commands and drives the read/load/inc/clear lines of NREG bus
// registers. A register's bus output follows its read line one clock late,
// so a transfer reads the source for one cycle (DRIVE) before loading the
// destination (LATCH).
//   clk   : rising-edge clock
//   clear : synchronous active-high reset
//   bus   : slave side of bus_xfer_ctrl_if (handshake, reg_* lines, status)
// -----------------------------------------------------------------------------
module bus_xfer_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int NREG = 8,
    parameter int SELW = 3
) (
    input  logic             clk,
    input  logic             clear,
    bus_xfer_ctrl_if.slave   bus
);
    localparam logic [SELW:0] NREG_L = (SELW+1)'(NREG);

    state_e          state_q, state_d;
    op_e             op_q;
    logic [SELW-1:0] src_q, dst_q;
    logic            done_q, done_d, err_q;
    logic            accept, cmd_bad;
    op_e             cmd_op;
    logic [NREG-1:0] src_oh, dst_oh;

    assign cmd_op        = op_e'(bus.cmd_op);
    assign bus.cmd_ready = (state_q == IDLE) && !clear;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // Rejected commands never leave IDLE; they only produce an err pulse.
    assign cmd_bad = ({1'b0, bus.cmd_src} >= NREG_L)
                  || ({1'b0, bus.cmd_dst} >= NREG_L)
                  || (is_transfer(cmd_op) && (bus.cmd_src == bus.cmd_dst));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            op_q    <= OP_MOVE;
            src_q   <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= cmd_op;
                src_q <= bus.cmd_src;
                dst_q <= bus.cmd_dst;
            end
            done_q <= done_d;
            err_q  <= accept && cmd_bad;
        end
    end

    // NOTE: defaults come first so every path assigns every output and no
    // latch is inferred.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (accept && !cmd_bad) state_d = is_transfer(cmd_op) ? DRIVE : EXEC;
            DRIVE: state_d = LATCH;
            LATCH: begin
                if (op_q == OP_MOVEINC) begin
                    state_d = INCR;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            EXEC: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            INCR: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    sel_decoder #(.NREG(NREG), .SELW(SELW)) u_src_dec (
        .sel    (src_q),
        .en     (state_q != IDLE),
        .onehot (src_oh)
    );

    sel_decoder #(.NREG(NREG), .SELW(SELW)) u_dst_dec (
        .sel    (dst_q),
        .en     (state_q != IDLE),
        .onehot (dst_oh)
    );

    // Source stays read through LATCH so the bus holds its value at the load edge.
    assign bus.reg_read  = src_oh & {NREG{(state_q == DRIVE) || (state_q == LATCH)}};
    assign bus.reg_load  = dst_oh & {NREG{state_q == LATCH}};
    assign bus.reg_inc   = (dst_oh & {NREG{(state_q == EXEC) && (op_q == OP_INC)}})
                         | (src_oh & {NREG{state_q == INCR}});
    assign bus.reg_clear = dst_oh & {NREG{(state_q == EXEC) && (op_q == OP_CLR)}};

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_xfer_ctrl
// Self-checking bench for bus_xfer_ctrl: directed vector table, hand-written
// reset / back-to-back sequences and randomized commands against a register
// file reference. A small DR-style register file is attached to the reg_*
// lines so data movement is observable.
// -----------------------------------------------------------------------------
module tb_bus_xfer_ctrl;
    import bus_ctrl_pkg::*;

    localparam int NREG = 8;
    localparam int SELW = 3;

    logic clk = 1'b0;
    logic clear;

    bus_xfer_ctrl_if #(.NREG(NREG), .SELW(SELW)) bus ();

    bus_xfer_ctrl #(.NREG(NREG), .SELW(SELW)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- register file attached to the control lines ----------
    logic [15:0]     rf [NREG];
    logic [NREG-1:0] drv_q;
    logic [15:0]     bus_val;
    logic            pre_en;
    int              pre_idx;
    logic [15:0]     pre_val;

    always_comb begin
        bus_val = '0;
        for (int i = 0; i < NREG; i++) if (drv_q[i] === 1'b1) bus_val |= rf[i];
    end

    always @(posedge clk) begin
        drv_q <= bus.reg_read;
        for (int i = 0; i < NREG; i++) begin
            if (pre_en && pre_idx == i) rf[i] <= pre_val;
            else if (bus.reg_clear[i])  rf[i] <= 16'h0000;
            else if (bus.reg_load[i])   rf[i] <= bus_val;
            else if (bus.reg_inc[i])    rf[i] <= rf[i] + 16'h0001;
        end
    end

    // ---------------- reference register contents ----------------
    logic [15:0] exp_rf [NREG];

    task automatic apply_ref(input logic [1:0] op, input int src, input int dst);
        case (op)
            OP_MOVE:    exp_rf[dst] = exp_rf[src];
            OP_CLR:     exp_rf[dst] = 16'h0000;
            OP_INC:     exp_rf[dst] = exp_rf[dst] + 16'h0001;
            default: begin
                exp_rf[dst] = exp_rf[src];
                exp_rf[src] = exp_rf[src] + 16'h0001;
            end
        endcase
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [15:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        exp_rf[idx] = val;
        sync();
        pre_en = 1'b0;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < NREG; i++)
            check($sformatf("%s_rf%0d", tag, i), rf[i], exp_rf[i]);
    endtask

    // Presents a command and returns one cycle after the accepting edge.
    task automatic send(input logic [1:0] op, input int src, input int dst);
        bit got = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src   = src[SELW-1:0];
        bus.cmd_dst   = dst[SELW-1:0];
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_wait", got, 1);
        sync();
        bus.cmd_valid = 1'b0;
    endtask

    function automatic logic [31:0] ctl_now();
        return {bus.reg_read, bus.reg_load, bus.reg_inc, bus.reg_clear};
    endfunction

    // ---------------- directed vector table ----------------
    // Per-cycle fields: byte [c-1] is the expected value in cycle c after accept.
    typedef struct packed {
        logic [1:0]      op;
        logic [2:0]      src;
        logic [2:0]      dst;
        int              lat;
        logic            err;
        logic [3:0][7:0] rd;
        logic [3:0][7:0] ld;
        logic [3:0][7:0] inc;
        logic [3:0][7:0] clr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        pre_en  = 1'b0;
        pre_idx = 0;
        pre_val = '0;
        clear   = 1'b1;

        vecs[0] = '{OP_MOVE,    3'd2, 3'd5, 3, 1'b0, 32'h0000_0404, 32'h0000_2000, 32'h0, 32'h0};
        vecs[1] = '{OP_MOVEINC, 3'd1, 3'd3, 4, 1'b0, 32'h0000_0202, 32'h0000_0800, 32'h0002_0000, 32'h0};
        vecs[2] = '{OP_CLR,     3'd0, 3'd7, 2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_0080};
        vecs[3] = '{OP_INC,     3'd0, 3'd0, 2, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 32'h0};
        vecs[4] = '{OP_MOVE,    3'd4, 3'd4, 1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[5] = '{OP_MOVEINC, 3'd6, 3'd6, 1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6] = '{OP_MOVE,    3'd7, 3'd0, 3, 1'b0, 32'h0000_8080, 32'h0000_0100, 32'h0, 32'h0};
        vecs[7] = '{OP_CLR,     3'd3, 3'd3, 2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_0008};

        // ---- power-on reset ----
        repeat (2) sync();
        @(negedge clk);
        check("rst_ctl",   ctl_now(), 32'h0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_err",   bus.err, 0);
        check("rst_ready", bus.cmd_ready, 0);
        clear = 1'b0;
        #1;
        check("rst_ready_release", bus.cmd_ready, 1);
        sync();

        for (int i = 0; i < NREG; i++) preload(i, 16'h1000 + 16'(i));
        preload(2, 16'h1234);
        preload(1, 16'hFFFF);

        // ---- table-driven commands ----
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].op, int'(vecs[i].src), int'(vecs[i].dst));
            for (int c = 1; c <= vecs[i].lat; c++) begin
                @(negedge clk);
                check($sformatf("v%0d_c%0d_ctl", i, c), ctl_now(),
                      {vecs[i].rd[c-1], vecs[i].ld[c-1], vecs[i].inc[c-1], vecs[i].clr[c-1]});
                check($sformatf("v%0d_c%0d_done", i, c), bus.done, (c == vecs[i].lat) && !vecs[i].err);
                check($sformatf("v%0d_c%0d_err", i, c),  bus.err,  vecs[i].err && (c == 1));
                check($sformatf("v%0d_c%0d_busy", i, c), bus.busy, c < vecs[i].lat);
            end
            if (!vecs[i].err) apply_ref(vecs[i].op, int'(vecs[i].src), int'(vecs[i].dst));
            if (i == 0) check("move_reg5", rf[5], 16'h1234);
            if (i == 1) begin
                check("moveinc_reg3", rf[3], 16'hFFFF);
                check("moveinc_reg1_wrap", rf[1], 16'h0000);
            end
            check_rf($sformatf("v%0d", i));
            sync();
        end

        // ---- clear held for three cycles during an active MOVE ----
        send(OP_MOVE, 2, 5);
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("midrst%0d_ctl", k),   ctl_now(), 32'h0);
            check($sformatf("midrst%0d_busy", k),  bus.busy, 0);
            check($sformatf("midrst%0d_ready", k), bus.cmd_ready, 0);
            check($sformatf("midrst%0d_done", k),  bus.done, 0);
            check($sformatf("midrst%0d_err", k),   bus.err, 0);
        end
        clear = 1'b0;
        #1;
        check("midrst_ready_release", bus.cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midrst_quiet%0d", k), {bus.done, bus.err, bus.busy}, 3'b000);
        end
        check_rf("midrst");
        sync();

        // ---- CLR 7 with INC 7 held while busy; INC accepted in done cycle ----
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_CLR;
        bus.cmd_src   = 3'd0;
        bus.cmd_dst   = 3'd7;
        @(negedge clk);
        check("b2b_ready0", bus.cmd_ready, 1);
        sync();
        bus.cmd_op = OP_INC;
        @(negedge clk);
        check("b2b_c1_ctl",   ctl_now(), {8'h00, 8'h00, 8'h00, 8'h80});
        check("b2b_c1_ready", bus.cmd_ready, 0);
        check("b2b_c1_done",  bus.done, 0);
        @(negedge clk);
        check("b2b_c2_done",  bus.done, 1);
        check("b2b_c2_ready", bus.cmd_ready, 1);
        check("b2b_c2_ctl",   ctl_now(), 32'h0);
        sync();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_c3_ctl",  ctl_now(), {8'h00, 8'h00, 8'h80, 8'h00});
        check("b2b_c3_done", bus.done, 0);
        @(negedge clk);
        check("b2b_c4_done", bus.done, 1);
        check("b2b_reg7",    rf[7], 16'h0001);
        apply_ref(OP_CLR, 0, 7);
        apply_ref(OP_INC, 0, 7);
        check_rf("b2b");
        sync();

        // ---- randomized commands against the reference ----
        for (int i = 0; i < NREG; i++) preload(i, 16'($urandom));
        for (int n = 0; n < 150; n++) begin
            logic [1:0] op;
            int src, dst, exp_lat, lat;
            bit bad, saw_err;
            op  = 2'($urandom_range(0, 3));
            src = $urandom_range(0, NREG - 1);
            dst = $urandom_range(0, NREG - 1);
            bad = ((op == OP_MOVE) || (op == OP_MOVEINC)) && (src == dst);
            exp_lat = bad ? 1 : (op == OP_MOVE) ? 3 : (op == OP_MOVEINC) ? 4 : 2;
            send(op, src, dst);
            lat = 0;
            saw_err = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                check($sformatf("r%0d_onehot", n),
                      {$onehot0(bus.reg_read), $onehot0(bus.reg_load),
                       $onehot0(bus.reg_inc), $onehot0(bus.reg_clear)}, 4'hF);
                if (bus.done === 1'b1 || bus.err === 1'b1) begin
                    lat = c;
                    saw_err = bus.err;
                    break;
                end
            end
            check($sformatf("r%0d_latency", n), lat, exp_lat);
            check($sformatf("r%0d_err", n), saw_err, bad);
            if (!bad) apply_ref(op, src, dst);
            check_rf($sformatf("r%0d", n));
            sync();
            if ($urandom_range(0, 3) == 0) sync();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
